// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared state type and default sizing for the convolution sequencer
package conv_pkg;
  localparam int DEF_F_SIZE   = 32;
  localparam int DEF_PIPE_LAT = 2;

  typedef enum logic [2:0] {
    LOAD_F,
    WAIT_X,
    MAC,
    DRAIN,
    WAIT_OUT
  } seq_state_t;
endpackage

// File: rtl/mac_valid_pipe.sv
// rtl/mac_valid_pipe.sv - tap valid/first delay line aligning accumulator control with the multiplier output
module mac_valid_pipe #(
  parameter int PIPE_LAT = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  input  logic in_valid,
  input  logic in_first,
  output logic acc_en,
  output logic acc_clr,
  output logic last
);
  localparam logic [PIPE_LAT-1:0] OUT_BIT = PIPE_LAT'(1) << (PIPE_LAT - 1);

  logic [PIPE_LAT-1:0] vld_sr;
  logic [PIPE_LAT-1:0] first_sr;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      vld_sr   <= '0;
      first_sr <= '0;
    end else begin
      vld_sr   <= (vld_sr << 1) | PIPE_LAT'(in_valid);
      first_sr <= (first_sr << 1) | PIPE_LAT'(in_valid && in_first);
    end
  end

  assign acc_en  = vld_sr[PIPE_LAT-1];
  assign acc_clr = first_sr[PIPE_LAT-1];
  // Final accumulate of the window: the output stage is the only live entry left.
  assign last    = vld_sr[PIPE_LAT-1] && ((vld_sr & ~OUT_BIT) == '0);
endmodule

// File: rtl/ctrl_fmem_mac_seq.sv
// rtl/ctrl_fmem_mac_seq.sv - filter load, tap walk and accumulator sequencing for one y per x window
module ctrl_fmem_mac_seq
  import conv_pkg::*;
#(
  parameter int F_SIZE   = DEF_F_SIZE,
  parameter int PIPE_LAT = DEF_PIPE_LAT,
  parameter int F_ADDR_W = (F_SIZE > 1) ? $clog2(F_SIZE) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                f_s_valid,
  output logic                f_s_ready,
  output logic                fmem_wr_en,
  output logic [F_ADDR_W-1:0] fmem_wr_addr,
  input  logic                x_window_valid,
  input  logic                out_accept,
  input  logic                conv_done,
  output logic [F_ADDR_W-1:0] tap_addr,
  output logic                acc_clr,
  output logic                acc_en,
  output logic                conv_start,
  output logic                busy
);
  localparam logic [F_ADDR_W-1:0] LAST_TAP = F_ADDR_W'(F_SIZE - 1);

  seq_state_t          state;
  seq_state_t          state_nxt;
  logic                ld_en_q;
  logic [F_ADDR_W-1:0] fill_cnt;
  logic [F_ADDR_W-1:0] tap_cnt;
  logic                conv_start_q;
  logic                fill_last;
  logic                tap_last;
  logic                pipe_last;

  assign f_s_ready    = ld_en_q && (state == LOAD_F);
  assign fmem_wr_en   = f_s_valid && f_s_ready && !conv_done;
  assign fmem_wr_addr = fill_cnt;
  assign tap_addr     = (state == MAC) ? tap_cnt : '0;
  assign busy         = (state == MAC) || (state == DRAIN);
  assign conv_start   = conv_start_q;
  assign fill_last    = (fill_cnt == LAST_TAP);
  assign tap_last     = (tap_cnt == LAST_TAP);

  always_ff @(posedge clk) begin
    if (reset) state <= LOAD_F;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (conv_done) begin
      state_nxt = LOAD_F;
    end else begin
      case (state)
        LOAD_F:   if (fmem_wr_en && fill_last) state_nxt = WAIT_X;
        WAIT_X:   if (x_window_valid)          state_nxt = MAC;
        MAC:      if (tap_last)                state_nxt = DRAIN;
        DRAIN:    if (pipe_last)               state_nxt = WAIT_OUT;
        WAIT_OUT: if (out_accept)              state_nxt = WAIT_X;
        default:                               state_nxt = LOAD_F;
      endcase
    end
  end

  // ld_en_q only drops on reset, so an abort reopens the filter stream at once.
  always_ff @(posedge clk) begin
    if (reset) ld_en_q <= 1'b0;
    else       ld_en_q <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset || conv_done) begin
      fill_cnt     <= '0;
      tap_cnt      <= '0;
      conv_start_q <= 1'b0;
    end else begin
      if (fmem_wr_en) fill_cnt <= fill_last ? '0 : fill_cnt + F_ADDR_W'(1);
      if (state == MAC) tap_cnt <= tap_last ? '0 : tap_cnt + F_ADDR_W'(1);
      else              tap_cnt <= '0;
      conv_start_q <= (state == DRAIN) && pipe_last;
    end
  end

  mac_valid_pipe #(
    .PIPE_LAT(PIPE_LAT)
  ) u_valid_pipe (
    .clk     (clk),
    .reset   (reset),
    .flush   (conv_done),
    .in_valid(state == MAC),
    .in_first(tap_cnt == '0),
    .acc_en  (acc_en),
    .acc_clr (acc_clr),
    .last    (pipe_last)
  );
endmodule
